// File: rtl/reg_file_pkg.sv
// Shared defaults, types and constants for the integer register file.
// Optional macro REGFILE_BYPASS_EN is consumed by reg_file_sb and rf_scoreboard.
package reg_file_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 5;
    localparam int NUM_REGS      = 2 ** ADDRESS_WIDTH;

    typedef logic [ADDRESS_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0]    reg_data_t;
    typedef logic [NUM_REGS-1:0]      pending_vec_t;

    // Architectural zero register: never written, never pending.
    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at
// writeback, wiped by flush. Provides per-read-port hazard lookup.
// With REGFILE_BYPASS_EN a same-cycle writeback masks the looked-up bit.
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDRESS_WIDTH = reg_file_pkg::ADDRESS_WIDTH,
    parameter int NUM_RD        = 2,
    parameter int NUM_WR        = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]             iss_addr,
    input  logic                                 flush,
    input  logic [NUM_WR-1:0]                    wr_en,
    input  logic [NUM_WR-1:0][ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_RD-1:0][ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]                    rd_pending,
    output logic                                 any_pending
);

    localparam int REG_COUNT = 2 ** ADDRESS_WIDTH;

    logic [REG_COUNT-1:0] pending_reg;
    logic [REG_COUNT-1:0] pending_next;

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_live
                logic wb_hit;
                logic set_hit;

                // Any enabled write port retiring into this register
                always_comb begin
                    wb_hit = 1'b0;
                    for (int p = 0; p < NUM_WR; p++) begin
                        if (wr_en[p] && wr_addr[p] == ADDRESS_WIDTH'(gi)) begin
                            wb_hit = 1'b1;
                        end
                    end
                end

                assign set_hit = iss_valid && (iss_addr == ADDRESS_WIDTH'(gi));

                // Flush beats issue; issue (newer producer) beats writeback
                assign pending_next[gi] = flush   ? 1'b0 :
                                          set_hit ? 1'b1 :
                                          wb_hit  ? 1'b0 : pending_reg[gi];
            end
        end
    endgenerate

    // Pending vector register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign any_pending = |pending_reg;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
            logic byp_hit;

            // A same-cycle writeback to the addressed register resolves the hazard
            always_comb begin
                byp_hit = 1'b0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && wr_addr[p] == rd_addr[gi]) begin
                        byp_hit = 1'b1;
                    end
                end
            end

            assign rd_pending[gi] = pending_reg[rd_addr[gi]] & ~byp_hit;
`else
            assign rd_pending[gi] = pending_reg[rd_addr[gi]];
`endif
        end
    endgenerate

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with pending-write scoreboard.
// Register 0 reads as zero; highest-indexed write port wins on conflict.
// Optional macro REGFILE_BYPASS_EN: write-first read ports (not debug port).
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH    = reg_file_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = reg_file_pkg::ADDRESS_WIDTH,
    parameter int NUM_RD        = 2,
    parameter int NUM_WR        = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_RD-1:0][ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]                    rd_pending,
    input  logic [NUM_WR-1:0]                    wr_en,
    input  logic [NUM_WR-1:0][ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wr_data,
    input  logic                                 iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]             iss_addr,
    input  logic                                 flush,
    output logic                                 any_pending,
    input  logic [ADDRESS_WIDTH-1:0]             testRegAddress,
    output logic [DATA_WIDTH-1:0]                testRegData
);

    localparam int                       REG_COUNT = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs_reg  [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_next [REG_COUNT];

    // Apply write ports in ascending order so the highest index wins
    always_comb begin
        regs_next = regs_reg;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && wr_addr[p] != ZERO_ADDR) begin
                regs_next[wr_addr[p]] = wr_data[p];
            end
        end
    end

    // Register storage with asynchronous clear; entry 0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_reg[r] <= '0;
            end
        end else begin
            regs_reg <= regs_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [DATA_WIDTH-1:0] rd_value;

            // Stored value, optionally overridden by a same-cycle write
            always_comb begin
                rd_value = regs_reg[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
                // Bypass held off during reset so reads stay zero
                for (int p = 0; p < NUM_WR; p++) begin
                    if (rst_n && wr_en[p] && wr_addr[p] == rd_addr[gi] &&
                        rd_addr[gi] != ZERO_ADDR) begin
                        rd_value = wr_data[p];
                    end
                end
`endif
            end

            assign rd_data[gi] = rd_value;
        end
    endgenerate

    assign testRegData = regs_reg[testRegAddress];

    rf_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_RD        (NUM_RD),
        .NUM_WR        (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid   (iss_valid),
        .iss_addr    (iss_addr),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .rd_pending  (rd_pending),
        .any_pending (any_pending)
    );

endmodule
